mem_access_unit: RTL and testbench

MEM-stage data-memory access unit, directly downstream of the MEM-stage control decode. It consumes MemWriteM, the load strobe and BEControlM for the instruction in MEM, and performs alignment checks. It then runs a request/acknowledge transaction on the data-memory bus, stalling the pipeline until the access completes, and returns lane-aligned, sign- or zero-extended load data toward the M/W register.

---
 rtl/mem_access_unit.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Checks load/store alignment, runs a req/ack transaction on the data bus
// while stalling the pipeline, and returns lane-aligned, extended load data.
// Optional feature macro: BUS_TIMEOUT_EN (bus-ack timeout raising BusErrM).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  BEControlM,
  input  logic        LoadSignM,
  input  logic        FlushM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        AdELM,
  output logic        AdESM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        aligned_s;
  logic        access_s;
  logic        start_s;
  logic        finish_s;
  logic        timeout_s;
  logic [1:0]  lane_r;
  logic [1:0]  size_r;
  logic        sign_r;

  // Byte-lane enables for the access size and address offset.
  function automatic logic [3:0] lane_be(input logic [1:0] bec, input logic [1:0] off);
    case (bec)
      2'b01:   lane_be = 4'b0001 << off;
      2'b10:   lane_be = 4'b0011 << {off[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so any enabled lane sees it.
  function automatic logic [31:0] lane_wdata(input logic [1:0] bec, input logic [31:0] wd);
    case (bec)
      2'b01:   lane_wdata = {4{wd[7:0]}};
      2'b10:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // Selects the addressed byte/half of the read word and extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] bec,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (bec)
      2'b01:   load_extend = {{24{sgn & b[7]}}, b};
      2'b10:   load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = rd;
    endcase
  endfunction

  // Natural-alignment check for the requested access size.
  always_comb begin
    aligned_s = 1'b1;
    case (BEControlM)
      2'b01:   aligned_s = 1'b1;
      2'b10:   aligned_s = ~AddrM[0];
      default: aligned_s = (AddrM[1:0] == 2'b00);
    endcase
  end

  assign access_s = (MemWriteM | MemReadM) & ~FlushM & aligned_s;
  assign AdELM    = MemReadM  & ~aligned_s & ~FlushM;
  assign AdESM    = MemWriteM & ~aligned_s & ~FlushM;

  // Next-state and stall decode; DONE always returns to IDLE so an access is never re-issued.
  always_comb begin
    state_nxt_s = state_r;
    StallM      = 1'b0;
    start_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        StallM = access_s;
        if (access_s) begin
          start_s     = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (bus_ack | timeout_s) begin
          finish_s    = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus request registers, captured lane info and load-data return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      ReadDataM <= 32'd0;
      lane_r    <= 2'd0;
      size_r    <= 2'd0;
      sign_r    <= 1'b0;
    end else if (start_s) begin
      bus_req   <= 1'b1;
      bus_we    <= MemWriteM;
      bus_addr  <= {AddrM[31:2], 2'b00};
      bus_be    <= lane_be(BEControlM, AddrM[1:0]);
      bus_wdata <= lane_wdata(BEControlM, WriteDataM);
      lane_r    <= AddrM[1:0];
      size_r    <= BEControlM;
      sign_r    <= LoadSignM;
    end else if (finish_s) begin
      bus_req   <= 1'b0;
      ReadDataM <= timeout_s ? 32'd0 : load_extend(bus_rdata, size_r, lane_r, sign_r);
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;

  assign timeout_s = (state_r == BUSY) & ~bus_ack & (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared on entry to BUSY, counts BUSY cycles without ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == BUSY) && !bus_ack) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Bus error pulse, high only during the DONE cycle that follows a timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BusErrM <= 1'b0;
    end else begin
      BusErrM <= finish_s & timeout_s;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign BusErrM   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit with a size/offset
// arithmetic reference model for lanes, store replication and load extension.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] AddrM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic        MemWriteM = 1'b0;
  logic        MemReadM = 1'b0;
  logic [1:0]  BEControlM = 2'd0;
  logic        LoadSignM = 1'b0;
  logic        FlushM = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        AdELM;
  logic        AdESM;
  logic        BusErrM;

  int          tests = 0;
  int          fails = 0;
  int          last_stalls;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic [31:0] last_addr;
  logic        last_we;
  logic [31:0] saved_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .BEControlM(BEControlM),
    .LoadSignM(LoadSignM), .FlushM(FlushM), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .StallM(StallM), .ReadDataM(ReadDataM), .AdELM(AdELM),
    .AdESM(AdESM), .BusErrM(BusErrM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes.
  function automatic int nbytes(input logic [1:0] bec);
    case (bec)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] bec);
    int n = nbytes(bec);
    int off = int'(addr % 32'd4);
    return 4'(((32'd1 << n) - 32'd1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] bec);
    int n = nbytes(bec);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                         input logic [1:0] bec, input logic sg);
    int n = nbytes(bec);
    logic [31:0] mask;
    logic [31:0] v;
    if (n == 4) return rd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rd >> (8 * (addr % 32'd4))) & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // One MEM instruction: ack arrives in the dly-th cycle after bus_req rises.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] bec, input logic sg, input logic [31:0] rd,
                            input int dly, input logic flush_busy);
    int   n;
    logic ok;
    int   cyc;
    bit   done;
    n  = nbytes(bec);
    ok = (addr % n) == 0;
    @(posedge clk); #1;
    MemWriteM = we; MemReadM = ~we; AddrM = addr; WriteDataM = wd;
    BEControlM = bec; LoadSignM = sg; FlushM = 1'b0;
    @(negedge clk);
    check("adel", 32'(AdELM), 32'(!we && !ok));
    check("ades", 32'(AdESM), 32'(we && !ok));
    if (!ok) begin
      check("stall_misaligned", 32'(StallM), 32'd0);
      @(negedge clk);
      check("req_misaligned", 32'(bus_req), 32'd0);
    end else begin
      cyc = 0; done = 1'b0; last_stalls = 0;
      while (!done && cyc < dly + 6) begin
        if (StallM !== 1'b1) begin
          done = 1'b1;
        end else begin
          last_stalls++;
          if (cyc >= 1) begin
            check("busy_req", 32'(bus_req), 32'd1);
            check("busy_we", 32'(bus_we), 32'(we));
            check("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
            check("busy_be", 32'(bus_be), 32'(m_be(addr, bec)));
            if (we) check("busy_wdata", bus_wdata, m_wdata(wd, bec));
            last_be = bus_be; last_wdata = bus_wdata; last_addr = bus_addr; last_we = bus_we;
          end
          @(posedge clk); #1;
          cyc++;
          bus_ack   = (cyc == dly);
          bus_rdata = (cyc == dly) ? rd : $urandom;
          if (flush_busy && cyc == 1) FlushM = 1'b1;
          @(negedge clk);
        end
      end
      bus_ack = 1'b0;
      check("stall_cycles", 32'(last_stalls), 32'(dly + 1));
      check("req_after_ack", 32'(bus_req), 32'd0);
      if (!we) check("load_data", ReadDataM, m_load(rd, addr, bec, sg));
    end
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemReadM = 1'b0; FlushM = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #12;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_buserr", 32'(BusErrM), 32'd0);
    check("rst_stall", 32'(StallM), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // SW word with ack two cycles after req.
    run_access(1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 2, 1'b0);
    check("sw_we", 32'(last_we), 32'd1);
    check("sw_be", 32'(last_be), 32'hF);
    check("sw_addr", last_addr, 32'h100);
    check("sw_stalls", 32'(last_stalls), 32'd3);

    // LB / LBU at byte lane 3.
    run_access(1'b0, 32'h203, 32'h0, 2'b01, 1'b1, 32'h80FF_1234, 1, 1'b0);
    check("lb_be", 32'(last_be), 32'h8);
    check("lb_data", ReadDataM, 32'hFFFFFF80);
    run_access(1'b0, 32'h203, 32'h0, 2'b01, 1'b0, 32'h80FF_1234, 3, 1'b0);
    check("lbu_data", ReadDataM, 32'h00000080);

    // SH on upper half.
    run_access(1'b1, 32'h302, 32'h0000ABCD, 2'b10, 1'b0, 32'h0, 1, 1'b0);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'hABCDABCD);

    // Misaligned LW and SH.
    run_access(1'b0, 32'h401, 32'h0, 2'b00, 1'b0, 32'h0, 1, 1'b0);
    run_access(1'b1, 32'h401, 32'h1234, 2'b10, 1'b0, 32'h0, 1, 1'b0);

    // Flush in IDLE suppresses request and address errors.
    @(posedge clk); #1;
    MemReadM = 1'b1; AddrM = 32'h501; BEControlM = 2'b00; FlushM = 1'b1;
    @(negedge clk);
    check("flush_adel", 32'(AdELM), 32'd0);
    check("flush_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1; AddrM = 32'h500;
    @(negedge clk);
    check("flush_stall_aligned", 32'(StallM), 32'd0);
    @(negedge clk);
    check("flush_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1; MemReadM = 1'b0; FlushM = 1'b0;

    // Flush raised during BUSY: transaction still completes.
    run_access(1'b0, 32'h504, 32'h0, 2'b10, 1'b1, 32'h1234_F00D, 3, 1'b1);
    check("flush_busy_data", ReadDataM, 32'hFFFFF00D);

    // ack outside BUSY is ignored.
    saved_rd = ReadDataM;
    @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("stray_ack_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1; bus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_req", 32'(bus_req), 32'd0);
    check("stray_ack_rdata", ReadDataM, saved_rd);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 63)), $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                 int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end

`ifdef BUS_TIMEOUT_EN
    // Never ack: timeout after TIMEOUT_CYCLES BUSY cycles.
    @(posedge clk); #1;
    MemReadM = 1'b1; AddrM = 32'h700; BEControlM = 2'b00;
    last_stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (StallM === 1'b1) last_stalls++;
      else break;
    end
    check("tmo_stalls", 32'(last_stalls), 32'd17);
    check("tmo_buserr", 32'(BusErrM), 32'd1);
    check("tmo_rdata", ReadDataM, 32'd0);
    check("tmo_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1; MemReadM = 1'b0;
    @(negedge clk);
    check("tmo_buserr_clear", 32'(BusErrM), 32'd0);
    check("tmo_idle_stall", 32'(StallM), 32'd0);
`endif

    // Reset in BUSY abandons the transaction; default build also shows BUSY waits indefinitely.
    @(posedge clk); #1;
    MemReadM = 1'b1; AddrM = 32'h600; BEControlM = 2'b00;
`ifdef BUS_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    check("wait_buserr", 32'(BusErrM), 32'd0);
`endif
    check("wait_stall", 32'(StallM), 32'd1);
    check("wait_req", 32'(bus_req), 32'd1);
    #2; reset_n = 1'b0; #1;
    check("rst_busy_req", 32'(bus_req), 32'd0);
    check("rst_busy_be", 32'(bus_be), 32'd0);
    MemReadM = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 32'(StallM), 32'd0);
    check("post_rst_req", 32'(bus_req), 32'd0);
    run_access(1'b0, 32'h602, 32'h0, 2'b10, 1'b0, 32'hBEEF_0000, 1, 1'b0);
    check("post_rst_load", ReadDataM, 32'h0000BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
